// File: rtl/set_assoc_cache_ctrl_if.sv
// CPU fetch/load port, DRAM refill port, flush control and statistics of the read cache.
// The cache controller takes the slave view; the requester/memory side takes the master view.
interface set_assoc_cache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cpu_hit;
  logic              flush;
  logic              flush_busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [WORD_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_rvalid, mem_rdata,
    output cpu_ready, cpu_rdata, cpu_hit, flush_busy, mem_req, mem_addr,
           hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_rvalid, mem_rdata,
    input  cpu_ready, cpu_rdata, cpu_hit, flush_busy, mem_req, mem_addr,
           hit_count, miss_count
  );
endinterface

// File: rtl/set_assoc_cache_ctrl.sv
// Direct-mapped or 2-way LRU read cache with burst refill, set-walk flush and hit/miss counters.
// state   | meaning
// IDLE    | wait for flush or cpu_req; flush has priority
// LOOKUP  | tag compare on the latched address
// REFILL  | fetch WPB beats into the line buffer
// RESPOND | return requested word from the line buffer
// FLUSH   | clear valid/LRU of one set per cycle
module set_assoc_cache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int WORD_W   = 32,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 2,
  parameter int ASSOC    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  set_assoc_cache_ctrl_if.slave bus
);
  localparam int SETS  = 2**INDEX_W;
  localparam int WPB   = 2**OFFSET_W;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESPOND, FLUSH} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   req_addr;
  logic [OFFSET_W-1:0] beat;
  logic [OFFSET_W-1:0] beat_nxt;
  logic                victim;
  logic                flush_pend;
  logic [INDEX_W-1:0]  flush_idx;
  logic                cpu_ready;
  logic                cpu_hit;
  logic [WORD_W-1:0]   cpu_rdata;
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                flush_busy;
  logic [CNT_W-1:0]    hit_cnt;
  logic [CNT_W-1:0]    miss_cnt;

  logic [TAG_W-1:0]    tag_mem  [ASSOC][SETS];
  logic [WORD_W-1:0]   data_mem [ASSOC][SETS][WPB];
  logic [WORD_W-1:0]   line_buf [WPB];
  logic [SETS-1:0]     valid    [ASSOC];
  logic [SETS-1:0]     lru;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                hit;
  logic                hit_way;
  logic                victim_sel;
  logic [WORD_W-1:0]   hit_word;
  logic                refill_last;
  logic                addr_lsb_unused;

  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr[OFFSET_W+2 +: INDEX_W];
  assign req_off  = req_addr[2 +: OFFSET_W];
  assign beat_nxt = beat + 1'b1;
  assign addr_lsb_unused = ^bus.cpu_addr[1:0];

  assign refill_last = (state == REFILL) && bus.mem_rvalid &&
                       (beat == OFFSET_W'(WPB - 1));

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < ASSOC; w++) begin
      if (valid[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  assign hit_word = data_mem[hit_way][req_idx][req_off];

  // lru[set] names the way to evict next; invalid ways are always filled first
  always_comb begin
    victim_sel = 1'b0;
    if (ASSOC == 2) begin
      if (!valid[0][req_idx])            victim_sel = 1'b0;
      else if (!valid[ASSOC-1][req_idx]) victim_sel = 1'b1;
      else                               victim_sel = lru[req_idx];
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Storage arrays carry no reset; only the valid bits decide what is resident.
  always_ff @(posedge clk) begin
    if ((state == REFILL) && bus.mem_rvalid)
      line_buf[beat] <= bus.mem_rdata;
    if (refill_last) begin
      tag_mem[victim][req_idx] <= req_tag;
      for (int b = 0; b < WPB; b++)
        data_mem[victim][req_idx][b] <= (b == WPB - 1) ? bus.mem_rdata : line_buf[b];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      beat       <= '0;
      victim     <= 1'b0;
      flush_pend <= 1'b0;
      flush_idx  <= '0;
      cpu_ready  <= 1'b0;
      cpu_hit    <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      flush_busy <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      lru        <= '0;
      for (int w = 0; w < ASSOC; w++) valid[w] <= '0;
    end else begin
      cpu_ready <= 1'b0;
      if (bus.flush && (state != IDLE) && (state != FLUSH))
        flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.flush || flush_pend) begin
            state      <= FLUSH;
            flush_pend <= 1'b0;
            flush_idx  <= '0;
            flush_busy <= 1'b1;
          end else if (bus.cpu_req && !cpu_ready) begin
            // a request still held during the ready pulse belongs to the previous transfer
            req_addr <= bus.cpu_addr;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_ready <= 1'b1;
            cpu_hit   <= 1'b1;
            cpu_rdata <= hit_word;
            hit_cnt   <= sat_inc(hit_cnt);
            if (ASSOC == 2) lru[req_idx] <= ~hit_way;
            state     <= IDLE;
          end else begin
            miss_cnt <= sat_inc(miss_cnt);
            beat     <= '0;
            victim   <= victim_sel;
            mem_req  <= 1'b1;
            mem_addr <= {req_addr[ADDR_W-1:OFFSET_W+2], {OFFSET_W{1'b0}}, 2'b00};
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (refill_last) begin
            mem_req                <= 1'b0;
            valid[victim][req_idx] <= 1'b1;
            if (ASSOC == 2) lru[req_idx] <= ~victim;
            state                  <= RESPOND;
          end else if (bus.mem_rvalid) begin
            beat     <= beat_nxt;
            mem_addr <= {req_addr[ADDR_W-1:OFFSET_W+2], beat_nxt, 2'b00};
          end
        end
        RESPOND: begin
          cpu_ready <= 1'b1;
          cpu_hit   <= 1'b0;
          cpu_rdata <= line_buf[req_off];
          state     <= IDLE;
        end
        FLUSH: begin
          for (int w = 0; w < ASSOC; w++) valid[w][flush_idx] <= 1'b0;
          lru[flush_idx] <= 1'b0;
          if (flush_idx == INDEX_W'(SETS - 1)) begin
            flush_busy <= 1'b0;
            state      <= IDLE;
          end else begin
            flush_idx <= flush_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ready  = cpu_ready;
  assign bus.cpu_hit    = cpu_hit;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = mem_addr;
  assign bus.flush_busy = flush_busy;
  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Randomised scoreboard bench for set_assoc_cache_ctrl: recency-list cache model,
// randomised-latency memory responder, hit-latency, flush-length and reset checks.
module tb_set_assoc_cache_ctrl;
  localparam int ADDR_W = 32, WORD_W = 32, INDEX_W = 10, OFFSET_W = 2, ASSOC = 2, CNT_W = 5;
  localparam int SETS = 2**INDEX_W;
  localparam int CNT_MAX = 2**CNT_W - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  set_assoc_cache_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  set_assoc_cache_ctrl #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .INDEX_W(INDEX_W),
    .OFFSET_W(OFFSET_W), .ASSOC(ASSOC), .CNT_W(CNT_W)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          hc;
    int          mc;
    int          raise;
    bit          chk_lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_beats[$];
  int checks = 0, errors = 0;
  int cyc = 0, beats_done = 0, flush_done = 0, fb_len = 0;
  bit fixed_lat = 1'b0;

  int unsigned mdl_tag [SETS][ASSOC];
  int          mdl_n   [SETS];
  int          mdl_hc = 0, mdl_mc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hA0 + {30'd0, a[3:2]} + (((a >> 4) - 32'd4) << 8);
  endfunction

  // Each set is a recency list: index 0 least recently used, last entry most recent.
  task automatic model_access(input logic [31:0] addr, output bit hit);
    int s;
    int unsigned t;
    int p;
    s = int'((addr >> 4) & (SETS - 1));
    t = addr >> 14;
    p = -1;
    for (int i = 0; i < mdl_n[s]; i++) if (mdl_tag[s][i] == t) p = i;
    hit = (p >= 0);
    if (hit) begin
      for (int i = p; i < mdl_n[s] - 1; i++) mdl_tag[s][i] = mdl_tag[s][i+1];
      mdl_tag[s][mdl_n[s]-1] = t;
      if (mdl_hc < CNT_MAX) mdl_hc++;
    end else begin
      if (mdl_n[s] == ASSOC) begin
        for (int i = 0; i < ASSOC - 1; i++) mdl_tag[s][i] = mdl_tag[s][i+1];
        mdl_tag[s][ASSOC-1] = t;
      end else begin
        mdl_tag[s][mdl_n[s]] = t;
        mdl_n[s]++;
      end
      if (mdl_mc < CNT_MAX) mdl_mc++;
    end
  endtask

  task automatic model_flush();
    for (int s = 0; s < SETS; s++) mdl_n[s] = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input bit lat_ok, input bit with_flush);
    exp_t e;
    bit   h;
    bit   got;
    if (with_flush) model_flush();
    model_access(addr, h);
    e.data    = memf({addr[31:2], 2'b00});
    e.hit     = h;
    e.hc      = mdl_hc;
    e.mc      = mdl_mc;
    e.raise   = cyc;
    e.chk_lat = lat_ok && !with_flush;
    if (!h) for (int b = 0; b < 4; b++) exp_beats.push_back({addr[31:4], 2'(b), 2'b00});
    exp_q.push_back(e);
    bus.cpu_addr = addr;
    bus.cpu_req  = 1'b1;
    if (with_flush) bus.flush = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      bus.flush = 1'b0;
      if (bus.cpu_ready) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL cpu_ready_timeout: no response for addr 0x%0h", addr);
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  // Response monitor
  logic prev_ready = 1'b0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst && bus.cpu_ready) begin
      chk("ready_single_pulse", prev_ready, 1'b0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cpu_ready_unexpected: rdata 0x%0h with no request pending", bus.cpu_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", bus.cpu_rdata, e.data);
        chk("hit", bus.cpu_hit, e.hit);
        chk("hit_count", bus.hit_count, e.hc);
        chk("miss_count", bus.miss_count, e.mc);
        if (e.hit && e.chk_lat) chk("hit_latency", cyc - e.raise, 2);
      end
    end
    prev_ready = rst && bus.cpu_ready;
  end

  // Flush length monitor
  initial forever begin
    @(negedge clk);
    if (rst && bus.flush_busy) fb_len++;
    else begin
      if (fb_len != 0) begin
        chk("flush_busy_len", fb_len, SETS);
        flush_done++;
      end
      fb_len = 0;
    end
  end

  // Memory responder: at least one idle cycle between beats
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst || bus.mem_rvalid || !bus.mem_req) begin
        bus.mem_rvalid = 1'b0;
        wcnt = fixed_lat ? 2 : int'($urandom_range(0, 2));
      end else if (wcnt != 0) begin
        wcnt--;
      end else begin
        if (exp_beats.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_req_unexpected: mem_addr 0x%0h", bus.mem_addr);
        end else begin
          chk("mem_addr", bus.mem_addr, exp_beats.pop_front());
        end
        bus.mem_rdata  = memf(bus.mem_addr);
        bus.mem_rvalid = 1'b1;
        beats_done++;
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int b0, fd0;
    logic [31:0] a;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    bus.flush    = 1'b0;
    model_flush();
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", bus.cpu_ready, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_flush_busy", bus.flush_busy, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_hit_count", bus.hit_count, 0);
    rst = 1'b1;
    @(negedge clk);

    // cold miss with 3-cycle beats, then hit in the same line
    fixed_lat = 1'b1;
    do_read(32'h0000_0040, 1'b1, 1'b0);
    fixed_lat = 1'b0;
    do_read(32'h0000_0048, 1'b1, 1'b0);

    // conflict eviction in set 4
    do_read(32'h0000_4040, 1'b1, 1'b0);
    do_read(32'h0000_0040, 1'b1, 1'b0);
    do_read(32'h0000_8040, 1'b1, 1'b0);
    do_read(32'h0000_0040, 1'b1, 1'b0);
    do_read(32'h0000_4040, 1'b1, 1'b0);

    for (int n = 0; n < 250; n++) begin
      int unsigned idx;
      idx = ($urandom_range(0, 3) == 3) ? $urandom_range(0, SETS - 1) : 4 + $urandom_range(0, 2);
      a = ($urandom_range(0, 3) << 14) | (idx << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      do_read(a, 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // flush raised mid-refill is deferred until the refill has answered
    b0 = beats_done;
    fd0 = flush_done;
    fork
      do_read(32'h0002_4040, 1'b1, 1'b0);
      begin
        for (int i = 0; i < 200 && beats_done == b0; i++) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
      end
    join
    model_flush();
    for (int i = 0; i < 3000 && flush_done == fd0; i++) @(negedge clk);
    chk("flush_after_refill_done", flush_done, fd0 + 1);
    do_read(32'h0000_0040, 1'b1, 1'b0);
    do_read(32'h0000_0044, 1'b1, 1'b0);

    // flush and request together: flush first, request then misses
    do_read(32'h0000_0040, 1'b0, 1'b1);

    // reset after the 2nd of 4 beats
    do_read(32'h0000_C050, 1'b1, 1'b0);
    b0 = beats_done;
    for (int b = 0; b < 4; b++) exp_beats.push_back(32'h0000_D050 | (b << 2));
    bus.cpu_addr = 32'h0000_D050;
    bus.cpu_req  = 1'b1;
    for (int i = 0; i < 200 && beats_done < b0 + 2; i++) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    chk("rstmid_mem_req", bus.mem_req, 0);
    chk("rstmid_cpu_ready", bus.cpu_ready, 0);
    chk("rstmid_cpu_hit", bus.cpu_hit, 0);
    chk("rstmid_cpu_rdata", bus.cpu_rdata, 0);
    chk("rstmid_mem_addr", bus.mem_addr, 0);
    chk("rstmid_miss_count", bus.miss_count, 0);
    exp_beats.delete();
    model_flush();
    mdl_hc = 0;
    mdl_mc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_read(32'h0000_0040, 1'b1, 1'b0);
    do_read(32'h0000_D050, 1'b1, 1'b0);
    do_read(32'h0000_D054, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    chk("resp_queue_drained", exp_q.size(), 0);
    chk("beat_queue_drained", exp_beats.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/set_assoc_cache_ctrl.md
Name: set_assoc_cache_ctrl

Overview:
- Clocked, parametrised read cache between the CPU fetch/load path and the word-wide DRAM model.
- Configurable as direct-mapped or 2-way set-associative (LRU replacement).
- Multi-cycle burst refill over a valid-handshake memory port; set-by-set flush; hit/miss counters.
- Replaces combinational lookup/refill with a registered FSM so hit and miss latency are deterministic and measurable.

Parameters:
ADDR_W, 32, byte address width
WORD_W, 32, data word width
INDEX_W, 10, set index bits (SETS = 2**INDEX_W)
OFFSET_W, 2, word-offset bits (WPB = 2**OFFSET_W words per line)
ASSOC, 2, ways; legal values 1 or 2
CNT_W, 16, hit/miss counter width
Derived: TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
cpu_req  in  1  read request, sampled only in IDLE
cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
cpu_ready  out  1  one-cycle pulse: cpu_rdata/cpu_hit valid
cpu_rdata  out  WORD_W  requested word
cpu_hit  out  1  1 = served from cache, 0 = served after refill
flush  in  1  invalidate-all request
flush_busy  out  1  high while flush walk in progress
mem_req  out  1  refill beat request
mem_addr  out  ADDR_W  word address of current beat {tag,index,beat,2'b00}
mem_rvalid  in  1  memory returns mem_rdata this cycle
mem_rdata  in  WORD_W  refill data
hit_count  out  CNT_W  hits since reset, saturating
miss_count  out  CNT_W  misses since reset, saturating

Behaviour:
- Reset (rst=0, async): state IDLE; all valid bits and LRU bits 0; cpu_ready, cpu_hit, mem_req, flush_busy 0; cpu_rdata 0; mem_addr 0; counters 0. Data/tag arrays not cleared.
- Reset mid-refill: refill aborted; no line, tag or valid written.
- FSM states: IDLE, LOOKUP, REFILL, RESPOND, FLUSH.
- IDLE:
  - flush=1 -> FLUSH (flush wins over a simultaneous cpu_req).
  - else cpu_req=1 -> latch cpu_addr, go to LOOKUP.
- LOOKUP (1 cycle): compare latched tag against every valid way of the indexed set.
  - Hit -> next cycle cpu_ready=1, cpu_hit=1, cpu_rdata = word[offset] of hit way; hit_count+1; LRU of set points to the other way; back to IDLE.
  - Hit latency: cpu_ready high in the 2nd cycle after the accepting edge.
  - Miss -> miss_count+1; beat counter = 0; REFILL.
- REFILL:
  - mem_req held 1, mem_addr = {tag, index, beat, 2'b00}.
  - Each cycle with mem_rvalid=1: store mem_rdata into the line buffer at [beat], increment beat, update mem_addr the next cycle.
  - No timeout; memory latency per beat is arbitrary (≥1 cycle).
  - On beat WPB-1 accepted: mem_req drops the next cycle; line, tag and valid written into the victim way; LRU points away from the victim; go to RESPOND.
- Victim selection: ASSOC=1 -> way 0. ASSOC=2 -> first invalid way (way 0 preferred), else way indicated by LRU bit.
- RESPOND (1 cycle): cpu_ready=1, cpu_hit=0, cpu_rdata = requested word taken from the line buffer; next IDLE.
- cpu_ready is low in every state except its single pulse. cpu_req is ignored outside IDLE; the requester holds it until cpu_ready.
- Flush:
  - flush asserted in any non-IDLE state is latched and serviced on the next IDLE entry; an in-progress refill completes first.
  - FLUSH clears valid and LRU of one set per cycle, index 0 to SETS-1; flush_busy=1 throughout; returns to IDLE after exactly SETS cycles.
  - flush re-asserted during FLUSH has no additional effect.
- Counters saturate at all-ones and do not wrap.
- Back-to-back requests: a new request is accepted in the cycle after cpu_ready (IDLE re-entry).

Test Plan:
- Cold miss, ASSOC=2, cpu_addr=0x0000_0040, memory returns 0xA0..0xA3 with 3-cycle beat latency -> mem_addr beats 0x40/0x44/0x48/0x4C; cpu_ready with cpu_hit=0, cpu_rdata=0xA0; miss_count=1.
- Repeat at 0x0000_0048 -> cpu_ready 2 cycles after accept, cpu_hit=1, cpu_rdata=0xA2, no mem_req; hit_count=1.
- Conflict eviction, INDEX_W=10: fill tags 0 and 1 at index 4 (0x40, 0x4040); hit 0x40; miss 0x8040 -> evicts 0x4040 line; re-read 0x40 hits, re-read 0x4040 misses. ASSOC=1 build: 0x4040 evicts 0x40.
- flush during a refill beat -> refill completes, cpu_ready pulse, then flush_busy high for exactly 1024 cycles; next read of 0x40 misses.
- Drive rst=0 after the 2nd of 4 beats -> mem_req and all outputs 0 immediately; after release, 0x40 misses.
- CNT_W=2, 5 hits -> hit_count stays 3.
